// File: rtl/serial_rca_adder.sv
// serial_rca_adder: bit-serial ripple-carry adder, one bit per clock, LSB first.
// Ports: clk, rst (async high), start, A, B in; busy, done, S, Cout, overflow out.
module serial_rca_adder #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] ps;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic             a0;
  logic             b0;
  logic             sbit;
  logic             cnext;
  logic             last;
  logic [WIDTH-1:0] ps_next;

  always_comb begin
    a0      = a_sr[0];
    b0      = b_sr[0];
    sbit    = a0 ^ b0 ^ cy;
    cnext   = (a0 & b0) | (a0 & cy) | (b0 & cy);
    last    = (cnt == CNT_W'(WIDTH-1));
    ps_next = {sbit, ps[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      ps       <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      S        <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            ps    <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          ps   <= ps_next;
          cy   <= cnext;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            // cy here is still the carry into the MSB slice
            S        <= ps_next;
            Cout     <= cnext;
            overflow <= cy ^ cnext;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rca_adder.sv
// tb_serial_rca_adder: randomized + directed checks of serial_rca_adder
// against an arithmetic reference model.
module tb_serial_rca_adder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  serial_rca_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .done     (done),
    .S        (s),
    .Cout     (cout),
    .overflow (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // reference: plain integer arithmetic
  function automatic int sx(input int v);
    return (v >= M/2) ? v - M : v;
  endfunction

  task automatic ref_add(input int x, input int y,
                         output int es, output int ec,
                         output int eo);
    int sv;
    es = (x + y) % M;
    ec = (x + y >= M) ? 1 : 0;
    sv = sx(x) + sx(y);
    eo = (sv > M/2 - 1 || sv < -M/2) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits for done; returns edges taken (-1 on timeout)
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  // poke: edge index after acceptance at which start is pulsed
  task automatic run_op(input string tag, input int x,
                        input int y, input int poke,
                        input bit full);
    int n, nb, es, ec, eo;
    ref_add(x, y, es, ec, eo);
    a = W'(x);
    b = W'(y);
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      start = (n == poke);
      if (n == poke) begin
        a = 4'd1;
        b = 4'd1;
      end
      tick();
      start = 1'b0;
      n++;
    end
    if (!done) n = -1;
    check({tag, ".S"}, int'(s), es);
    if (full) begin
      check({tag, ".lat"}, n, W);
      check({tag, ".busy"}, nb, W);
      check({tag, ".cout"}, int'(cout), ec);
      check({tag, ".ovf"}, int'(ovf), eo);
      tick();
      check({tag, ".pulse"}, int'(done), 0);
    end
  endtask

  initial begin
    int n, nb, c0, es, ec, eo;
    #12;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.S", int'(s), 0);
    check("rst.cout", int'(cout), 0);
    check("rst.ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("d5p3", 5, 3, -1, 1'b1);
    run_op("d15p1", 15, 1, -1, 1'b1);
    run_op("d9p9", 9, 9, -1, 1'b1);
    run_op("ign", 6, 7, 1, 1'b1);

    // reset mid-operation
    a = 4'd10;
    b = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mrst.S", int'(s), 0);
    check("mrst.cout", int'(cout), 0);
    check("mrst.ovf", int'(ovf), 0);
    check("mrst.busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) nb++;
    end
    check("mrst.nodone", nb, 0);
    run_op("d2p2", 2, 2, -1, 1'b1);

    // back-to-back
    a = 4'd3;
    b = 4'd4;
    start = 1'b1;
    tick();
    a = W'($urandom);
    b = W'($urandom);
    wait_done(n, nb);
    c0 = cyc;
    check("b2b.lat1", n, W);
    check("b2b.S1", int'(s), 7);
    check("b2b.cout1", int'(cout), 0);
    a = 4'd12;
    b = 4'd12;
    tick();
    start = 1'b0;
    check("b2b.busy", int'(busy), 1);
    wait_done(n, nb);
    check("b2b.gap", cyc - c0, W + 1);
    check("b2b.S2", int'(s), 8);
    check("b2b.cout2", int'(cout), 1);
    check("b2b.ovf2", int'(ovf), 0);
    tick();

    // random operands
    for (int i = 0; i < 40; i++) begin
      run_op("rnd", int'($urandom_range(M-1)),
             int'($urandom_range(M-1)), -1, 1'b1);
    end

    // round trip with subtractor results
    for (int x = 0; x < M; x++) begin
      for (int y = 0; y < M; y++) begin
        ref_add((x - y + M) % M, y, es, ec, eo);
        if (es != x) begin
          $display("FAIL model.rt: got %0d expected %0d", es, x);
          n_bad++;
        end
        run_op("rt", (x - y + M) % M, y, -1, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
    $finish;
  end

endmodule
